// File: rtl/env_mixer_if.sv
// ---------------------------------------------------------------------------
// env_mixer_if -- sample/envelope bus of the four-voice envelope mixer.
//
// Signals
//   sample_ena    one-cycle pulse that starts a new sample period
//   s1..s4        unsigned 4-bit raw voice samples
//   gate          per-voice note-on level, bit i belongs to voice s(i+1)
//   sample        mixed, enveloped 4-bit sample for the PWM stage
//   sample_valid  one-cycle pulse when sample updates
//   env_o         envelope levels, env_o[4i+3:4i] = voice i
//   overrun       sticky flag, set when a sample_ena is dropped
//
// Modports
//   master  drives the voice inputs, observes the mixer outputs
//   slave   the mixer itself
// ---------------------------------------------------------------------------
interface env_mixer_if;
  logic        sample_ena;
  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [3:0]  s3;
  logic [3:0]  s4;
  logic [3:0]  gate;
  logic [3:0]  sample;
  logic        sample_valid;
  logic [15:0] env_o;
  logic        overrun;

  modport master (
    output sample_ena, s1, s2, s3, s4, gate,
    input  sample, sample_valid, env_o, overrun
  );

  modport slave (
    input  sample_ena, s1, s2, s3, s4, gate,
    output sample, sample_valid, env_o, overrun
  );
endinterface

// File: rtl/env_mixer.sv
// ---------------------------------------------------------------------------
// env_mixer -- four-voice envelope generator and mixer.
//
// On an accepted sample_ena (cycle T) the voice samples are captured, the
// envelope divider advances and every voice's envelope FSM steps once. The
// following four cycles multiply each captured sample by its fresh envelope
// level and accumulate the top nibble of the product; at T+5 the
// accumulator's top four bits are published with a one-cycle sample_valid.
// A sample_ena that arrives while a pass is still running is dropped and
// latches the sticky overrun flag.
//
// Parameters
//   ENV_DIV   accepted sample_ena pulses per envelope step (1..1024)
//
// Ports
//   clock     rising-edge clock for all state
//   reset_n   asynchronous active-low reset
//   bus       env_mixer_if.slave (voice inputs, mixed output, status)
// ---------------------------------------------------------------------------
module env_mixer #(
  parameter int ENV_DIV = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  env_mixer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  typedef struct packed {
    env_state_t state;
    logic [3:0] env;
  } voice_t;

  localparam logic [9:0] DIV_LAST  = 10'(ENV_DIV - 1);
  // Sequencer step on which the result is published and a new pulse may enter.
  localparam logic [2:0] STEP_DONE = 3'd4;

  logic        r_busy;
  logic [2:0]  r_step;
  logic [3:0]  r_cap [4];
  voice_t      r_voice [4];
  logic [9:0]  r_div;
  logic [5:0]  r_acc;
  logic [3:0]  r_sample;
  logic        r_valid;
  logic        r_overrun;

  logic [3:0]  w_s [4];
  logic        w_accept;
  logic        w_tick;
  logic [1:0]  w_sel;
  logic [7:0]  w_prod;

  assign w_s[0] = bus.s1;
  assign w_s[1] = bus.s2;
  assign w_s[2] = bus.s3;
  assign w_s[3] = bus.s4;

  // The publishing cycle counts as idle so passes can run back to back.
  assign w_accept = bus.sample_ena && (!r_busy || (r_step == STEP_DONE));
  assign w_tick   = (r_div == DIV_LAST);
  assign w_sel    = r_step[1:0];
  assign w_prod   = {4'b0000, r_cap[w_sel]} * {4'b0000, r_voice[w_sel].env};

  // One envelope step for a single voice: the gate-driven transition is
  // taken first, then the tick action of the state just entered applies.
  function automatic voice_t voice_next(input voice_t cur, input logic gate_bit,
                                        input logic tick);
    voice_t nxt;
    nxt = cur;
    case (cur.state)
      ST_IDLE:    if (gate_bit)  nxt.state = ST_ATTACK;
      ST_ATTACK:  if (!gate_bit) nxt.state = ST_RELEASE;
      ST_SUSTAIN: if (!gate_bit) nxt.state = ST_RELEASE;
      ST_RELEASE: if (gate_bit)  nxt.state = ST_ATTACK;
    endcase
    if (tick) begin
      case (nxt.state)
        ST_ATTACK: begin
          if (nxt.env != 4'd15) nxt.env = nxt.env + 4'd1;
          if (nxt.env == 4'd15) nxt.state = ST_SUSTAIN;
        end
        ST_RELEASE: begin
          if (nxt.env != 4'd0) nxt.env = nxt.env - 4'd1;
          if (nxt.env == 4'd0) nxt.state = ST_IDLE;
        end
        default: ;  // IDLE stays at 0, SUSTAIN stays at 15
      endcase
    end
    return nxt;
  endfunction

  // NOTE: every flop below, including the small per-voice arrays, is
  // assigned with <= and cleared by the async reset; the arrays are only
  // four entries of flops, not a RAM, so resetting them costs nothing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= 1'b0;
      r_step    <= 3'd0;
      r_div     <= 10'd0;
      r_acc     <= 6'd0;
      r_sample  <= 4'd0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_cap[i]   <= 4'd0;
        r_voice[i] <= '{state: ST_IDLE, env: 4'd0};
      end
    end else begin
      r_valid <= 1'b0;

      if (bus.sample_ena && !w_accept) begin
        r_overrun <= 1'b1;
      end

      // Mix pass: steps 0..3 accumulate voices 0..3, step 4 publishes.
      if (r_busy) begin
        if (r_step == STEP_DONE) begin
          r_sample <= r_acc[5:2];
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
        end else begin
          r_acc  <= r_acc + 6'(w_prod >> 4);
          r_step <= r_step + 3'd1;
        end
      end

      // An accept on the publishing cycle overrides the busy release above.
      if (w_accept) begin
        r_busy <= 1'b1;
        r_step <= 3'd0;
        r_acc  <= 6'd0;
        r_div  <= w_tick ? 10'd0 : r_div + 10'd1;
        for (int i = 0; i < 4; i++) begin
          r_cap[i]   <= w_s[i];
          r_voice[i] <= voice_next(r_voice[i], bus.gate[i], w_tick);
        end
      end
    end
  end

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.overrun      = r_overrun;
  assign bus.env_o        = {r_voice[3].env, r_voice[2].env,
                             r_voice[1].env, r_voice[0].env};

endmodule

// File: tb/tb_env_mixer.sv
// ---------------------------------------------------------------------------
// tb_env_mixer -- self-checking bench for env_mixer.
//
// Two instances run side by side on identical stimulus: one with ENV_DIV=1
// and one with ENV_DIV=4. A per-pulse envelope model (index 0 = ENV_DIV 1,
// index 1 = ENV_DIV 4) predicts envelope levels and the mixed sample.
// ---------------------------------------------------------------------------
module tb_env_mixer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  env_mixer_if bus1 ();
  env_mixer_if bus4 ();

  env_mixer #(.ENV_DIV(1)) dut1 (.clock(clk), .reset_n(rst_n), .bus(bus1));
  env_mixer #(.ENV_DIV(4)) dut4 (.clock(clk), .reset_n(rst_n), .bus(bus4));

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  typedef enum {PH_OFF, PH_UP, PH_HOLD, PH_DOWN} phase_t;

  int         m_env [2][4];
  phase_t     m_ph  [2][4];
  int         m_cnt [2];
  logic [3:0] m_samp [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_samp[k] = 4'd0;
      for (int v = 0; v < 4; v++) begin
        m_env[k][v] = 0;
        m_ph[k][v]  = PH_OFF;
      end
    end
  endfunction

  function automatic void model_accept(int k, logic [15:0] sv, logic [3:0] g);
    int div = (k == 0) ? 1 : 4;
    int sum = 0;
    bit tick;
    tick     = (m_cnt[k] == div - 1);
    m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
    for (int v = 0; v < 4; v++) begin
      if (g[v]) begin
        if (m_ph[k][v] == PH_OFF || m_ph[k][v] == PH_DOWN) m_ph[k][v] = PH_UP;
      end else if (m_ph[k][v] == PH_UP || m_ph[k][v] == PH_HOLD) begin
        m_ph[k][v] = PH_DOWN;
      end
      if (tick && m_ph[k][v] == PH_UP) begin
        m_env[k][v] = (m_env[k][v] < 15) ? m_env[k][v] + 1 : 15;
        if (m_env[k][v] == 15) m_ph[k][v] = PH_HOLD;
      end else if (tick && m_ph[k][v] == PH_DOWN) begin
        m_env[k][v] = (m_env[k][v] > 0) ? m_env[k][v] - 1 : 0;
        if (m_env[k][v] == 0) m_ph[k][v] = PH_OFF;
      end
      sum += (int'(sv[4*v +: 4]) * m_env[k][v]) / 16;
    end
    m_samp[k] = 4'(sum / 4);
  endfunction

  function automatic logic [15:0] model_env(int k);
    logic [15:0] r;
    for (int v = 0; v < 4; v++) r[4*v +: 4] = 4'(m_env[k][v]);
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int          vcount;
    int          vcyc;
    logic [3:0]  samp;
    logic [3:0]  samp_end;
    logic [15:0] env;
    logic        ovr;
  } obs_t;

  obs_t obs [2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(logic ena, logic [15:0] sv, logic [3:0] g);
    bus1.sample_ena = ena;  bus4.sample_ena = ena;
    bus1.s1 = sv[3:0];      bus4.s1 = sv[3:0];
    bus1.s2 = sv[7:4];      bus4.s2 = sv[7:4];
    bus1.s3 = sv[11:8];     bus4.s3 = sv[11:8];
    bus1.s4 = sv[15:12];    bus4.s4 = sv[15:12];
    bus1.gate = g;          bus4.gate = g;
  endtask

  function automatic logic [21:0] dut_outs(int k);
    if (k == 0) return {bus1.sample, bus1.sample_valid, bus1.env_o, bus1.overrun};
    return {bus4.sample, bus4.sample_valid, bus4.env_o, bus4.overrun};
  endfunction

  task automatic do_reset();
    set_inputs(1'b0, 16'h0000, 4'h0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  // One accepted pulse followed by gap-1 idle cycles (gap >= 6), observing
  // both instances; the model is advanced for the pulse.
  task automatic run_pass(logic [15:0] sv, logic [3:0] g, int gap);
    set_inputs(1'b1, sv, g);
    step();
    set_inputs(1'b0, sv, g);
    model_accept(0, sv, g);
    model_accept(1, sv, g);
    for (int k = 0; k < 2; k++) begin
      obs[k].vcount = 0;
      obs[k].vcyc   = -1;
      obs[k].samp   = 4'hx;
    end
    obs[0].env = bus1.env_o;
    obs[1].env = bus4.env_o;
    for (int c = 1; c < gap; c++) begin
      step();
      if (bus1.sample_valid) begin
        obs[0].vcount++; obs[0].vcyc = c; obs[0].samp = bus1.sample;
      end
      if (bus4.sample_valid) begin
        obs[1].vcount++; obs[1].vcyc = c; obs[1].samp = bus4.sample;
      end
    end
    obs[0].samp_end = bus1.sample;  obs[0].ovr = bus1.overrun;
    obs[1].samp_end = bus4.sample;  obs[1].ovr = bus4.overrun;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [21:0] o;
    set_inputs(1'b0, 16'h0000, 4'h0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      o = dut_outs(k);
      n_total++;
      if (o !== 22'd0) $display("FAIL reset_state dut%0d: got %h, want 0", k, o);
      else n_pass++;
    end
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    for (int p = 1; p <= 18; p++) begin
      run_pass(16'h000F, 4'b0001, 8);
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs[k].env !== model_env(k) || obs[k].vcount != 1 || obs[k].vcyc != 5 ||
            obs[k].samp !== m_samp[k] || obs[k].samp_end !== m_samp[k])
          $display("FAIL ramp pass%0d dut%0d: env=%h valid=%0dx@%0d sample=%0d/%0d want env=%h 1x@5 sample=%0d",
                   p, k, obs[k].env, obs[k].vcount, obs[k].vcyc, obs[k].samp,
                   obs[k].samp_end, model_env(k), m_samp[k]);
        else n_pass++;
      end
      n_total++;
      if (obs[0].env[3:0] !== 4'((p < 15) ? p : 15) ||
          (p >= 15 && obs[0].samp !== 4'd3))
        $display("FAIL ramp_level pass%0d: env0=%0d sample=%0d want env0=%0d (sample 3 once at 15)",
                 p, obs[0].env[3:0], obs[0].samp, (p < 15) ? p : 15);
      else n_pass++;
    end
  endtask

  task automatic test_all_max();
    for (int p = 1; p <= 62; p++) begin
      run_pass(16'hFFFF, 4'hF, 6);
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs[k].env !== model_env(k) || obs[k].samp !== m_samp[k] || obs[k].vcyc != 5)
          $display("FAIL all_max pass%0d dut%0d: env=%h sample=%0d at %0d want env=%h sample=%0d at 5",
                   p, k, obs[k].env, obs[k].samp, obs[k].vcyc, model_env(k), m_samp[k]);
        else n_pass++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obs[k].env !== 16'hFFFF || obs[k].samp !== 4'd14)
        $display("FAIL all_max_final dut%0d: env=%h sample=%0d want env=ffff sample=14",
                 k, obs[k].env, obs[k].samp);
      else n_pass++;
    end
  endtask

  // Attack to env 7 with ENV_DIV=4, then release down to idle.
  task automatic test_attack_release();
    int want;
    do_reset();
    for (int p = 1; p <= 28; p++) begin
      run_pass(16'h000F, 4'b0001, 6);
      want = p / 4;
      n_total++;
      if (obs[1].env[3:0] !== 4'(want) || obs[1].env !== model_env(1) || obs[0].env !== model_env(0))
        $display("FAIL attack pass%0d: env4=%h env1=%h want env4 voice0=%0d model %h/%h",
                 p, obs[1].env, obs[0].env, want, model_env(1), model_env(0));
      else n_pass++;
    end
    for (int q = 1; q <= 30; q++) begin
      run_pass(16'h000F, 4'b0000, 6);
      want = (7 - q / 4 > 0) ? 7 - q / 4 : 0;
      n_total++;
      if (obs[1].env[3:0] !== 4'(want) || obs[1].samp !== m_samp[1] || obs[0].env !== model_env(0))
        $display("FAIL release pass%0d: env4 voice0=%0d sample=%0d env1=%h want %0d sample=%0d env1=%h",
                 q, obs[1].env[3:0], obs[1].samp, obs[0].env, want, m_samp[1], model_env(0));
      else n_pass++;
    end
  endtask

  // Re-gate during release at env 5: attack must resume from 5.
  task automatic test_retrigger();
    int want;
    do_reset();
    for (int p = 1; p <= 28; p++) run_pass(16'h000F, 4'b0001, 6);
    for (int q = 1; q <= 8; q++) run_pass(16'h000F, 4'b0000, 6);
    n_total++;
    if (obs[1].env[3:0] !== 4'd5) $display("FAIL retrigger_setup: env4 voice0=%0d want 5", obs[1].env[3:0]);
    else n_pass++;
    for (int r = 1; r <= 8; r++) begin
      run_pass(16'h000F, 4'b0001, 6);
      want = (r < 4) ? 5 : ((r < 8) ? 6 : 7);
      n_total++;
      if (obs[1].env[3:0] !== 4'(want) || obs[1].env !== model_env(1))
        $display("FAIL retrigger pass%0d: env4 voice0=%0d want %0d", r, obs[1].env[3:0], want);
      else n_pass++;
    end
  endtask

  // Pulses at T, T+2 (dropped) and T+5 (accepted).
  task automatic test_back_to_back();
    logic [3:0]  samp_a [2];
    logic [21:0] o;
    int vcnt [2], first_cyc [2], last_cyc [2];
    logic [3:0]  first_s [2], last_s [2];
    do_reset();
    run_pass(16'hFFFF, 4'hF, 8);
    run_pass(16'hFFFF, 4'hF, 8);
    set_inputs(1'b1, 16'h9F5A, 4'hF);
    step();
    model_accept(0, 16'h9F5A, 4'hF);
    model_accept(1, 16'h9F5A, 4'hF);
    for (int k = 0; k < 2; k++) begin
      samp_a[k] = m_samp[k];
      vcnt[k] = 0; first_cyc[k] = -1; last_cyc[k] = -1;
      first_s[k] = 4'hx; last_s[k] = 4'hx;
      o = dut_outs(k);
      n_total++;
      if (o[0] !== 1'b0) $display("FAIL overrun_clean dut%0d: got %b want 0", k, o[0]);
      else n_pass++;
    end
    for (int c = 1; c <= 10; c++) begin
      set_inputs((c == 2) || (c == 5), 16'h9F5A, 4'hF);
      step();
      if (c == 5) begin
        model_accept(0, 16'h9F5A, 4'hF);
        model_accept(1, 16'h9F5A, 4'hF);
      end
      for (int k = 0; k < 2; k++) begin
        o = dut_outs(k);
        if (o[17]) begin
          vcnt[k]++;
          if (first_cyc[k] < 0) begin first_cyc[k] = c; first_s[k] = o[21:18]; end
          last_cyc[k] = c; last_s[k] = o[21:18];
        end
        if (c == 2 || c == 5) begin
          n_total++;
          if (o[0] !== 1'b1 || o[16:1] !== model_env(k))
            $display("FAIL overrun_c%0d dut%0d: overrun=%b env=%h want 1 env=%h",
                     c, k, o[0], o[16:1], model_env(k));
          else n_pass++;
        end
      end
    end
    set_inputs(1'b0, 16'h0000, 4'hF);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (vcnt[k] != 2 || first_cyc[k] != 5 || last_cyc[k] != 10 ||
          first_s[k] !== samp_a[k] || last_s[k] !== m_samp[k])
        $display("FAIL back_to_back dut%0d: %0d valids at %0d/%0d samples %0d/%0d want 2 at 5/10 samples %0d/%0d",
                 k, vcnt[k], first_cyc[k], last_cyc[k], first_s[k], last_s[k], samp_a[k], m_samp[k]);
      else n_pass++;
    end
  endtask

  // Reset asserted at T+3 of a pass.
  task automatic test_reset_mid();
    logic [21:0] o;
    int vcnt = 0;
    do_reset();
    run_pass(16'hFFFF, 4'hF, 8);
    run_pass(16'hFFFF, 4'hF, 8);
    set_inputs(1'b1, 16'hFFFF, 4'hF);
    step();
    set_inputs(1'b0, 16'hFFFF, 4'hF);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      o = dut_outs(k);
      n_total++;
      if (o !== 22'd0) $display("FAIL reset_mid dut%0d: got %h want 0", k, o);
      else n_pass++;
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin rst_n = 1'b1; model_reset(); end
      step();
      if (bus1.sample_valid || bus4.sample_valid) vcnt++;
    end
    n_total++;
    if (vcnt != 0) $display("FAIL reset_mid_valid: %0d stray valids want 0", vcnt);
    else n_pass++;
    for (int p = 1; p <= 3; p++) begin
      run_pass(16'hFFFF, 4'hF, 7);
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs[k].env !== model_env(k) || obs[k].vcount != 1 || obs[k].vcyc != 5 || obs[k].samp !== m_samp[k])
          $display("FAIL after_reset pass%0d dut%0d: env=%h valid=%0dx@%0d sample=%0d want env=%h 1x@5 sample=%0d",
                   p, k, obs[k].env, obs[k].vcount, obs[k].vcyc, obs[k].samp, model_env(k), m_samp[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] sv;
    logic [3:0]  g = 4'hF;
    do_reset();
    for (int p = 1; p <= 60; p++) begin
      sv = 16'($urandom);
      if ($urandom_range(0, 4) == 0) g = 4'($urandom);
      run_pass(sv, g, int'($urandom_range(6, 10)));
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs[k].env !== model_env(k) || obs[k].vcount != 1 || obs[k].vcyc != 5 ||
            obs[k].samp !== m_samp[k] || obs[k].samp_end !== m_samp[k] || obs[k].ovr !== 1'b0)
          $display("FAIL random pass%0d dut%0d: env=%h valid=%0dx@%0d sample=%0d/%0d ovr=%b want env=%h 1x@5 sample=%0d ovr=0",
                   p, k, obs[k].env, obs[k].vcount, obs[k].vcyc, obs[k].samp, obs[k].samp_end,
                   obs[k].ovr, model_env(k), m_samp[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_all_max();
    test_attack_release();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
